reg_activity_tracker: RTL
=========================

// Module: reg_activity_tracker
// PURPOSE
//  Parametrised register-file shadow for the VGA debug display. Holds NUM_REGS
//  registers, generates demo activity (sequential, pseudo-random, single-step)
//  or snoops a real CPU writeback port. Flags recently written registers via
//  changed_mask. Outputs are consumed by risc_debug_display in place of a fixed
//  demo array.
// PARAMETERS
//  NUM_REGS     32            register count; power of 2, 4..32
//  DATA_W       32            register width; 8..32
//  STEP_PERIOD  16_777_216    cycles between demo updates (>=2)
//  HOLD_CYCLES  8_388_608     highlight hold after last update (>=2)
//  LFSR_SEED    32'hACE12468  LFSR reset value; must be non-zero
// PORTS
//  clock         in   1                  system clock, 50 MHz
//  sw0           in   1                  reset: async, active-high
//  mode          in   2                  00 seq, 01 lfsr, 10 snoop, 11 freeze
//  step_pulse    in   1                  1-cycle manual step; mode 11 only
//  wb_we         in   1                  CPU writeback enable; mode 10 only
//  wb_addr       in   $clog2(NUM_REGS)   CPU writeback register index
//  wb_data       in   DATA_W             CPU writeback data
//  regs_flat     out  NUM_REGS*DATA_W    reg i at [i*DATA_W +: DATA_W]
//  changed_mask  out  NUM_REGS           1 = reg updated within hold window
//  last_reg      out  $clog2(NUM_REGS)   index of most recent update
//  update_count  out  16                 updates since reset; saturates FFFF
// BEHAVIOUR
//  Reset (async, immediate, any state):
//  - reg0 = 0. reg i = (i * 32'h01010101) truncated to DATA_W.
//  - mask = 0, last_reg = 0, update_count = 0.
//  - step timer = 0, hold timer = 0, ptr = 1, lfsr = LFSR_SEED.
//  Step timer (modes 00/01):
//  - Counts 0..STEP_PERIOD-1.
//  - tick at STEP_PERIOD-1, then wraps to 0.
//  Mode 11:
//  - Timer held at 0.
//  - step_pulse = tick, applied as a seq update.
//  Any mode change clears the step timer. ptr, lfsr and mask are kept.
//  Seq update:
//  - reg[ptr] += 1, mod 2^DATA_W.
//  - ptr advances 1..NUM_REGS-1, then wraps to 1. Never 0.
//  LFSR update:
//  - 32-bit Galois LFSR, taps 32'h80200003, advances once per tick.
//  - tgt = new_lfsr[ADDR_W-1:0]; tgt 0 maps to 1.
//  - reg[tgt] = new_lfsr[DATA_W-1:0].
//  Snoop (mode 10):
//  - Each cycle with wb_we=1 and wb_addr!=0: reg[wb_addr] = wb_data. No tick.
//  - wb_addr 0 writes are ignored (no event).
//  - wb_we is ignored in all other modes.
//  Update event (tick or accepted write):
//  - Set mask[idx], last_reg = idx, update_count +1 (saturating), hold timer = 0.
//  - Writing an unchanged value still counts as an event.
//  Hold timer:
//  - Increments while mask != 0.
//  - At HOLD_CYCLES-1 with no event that cycle, mask is cleared next cycle.
//  - If an event coincides with expiry, the event wins: its bit is set, other
//    bits are kept, timer restarts.
//  Timing:
//  - All outputs are registered.
//  - Latency: event cycle -> outputs valid on the next rising edge.
//  - reg0 always reads 0.
// TESTING (NUM_REGS=8, DATA_W=16, STEP_PERIOD=4, HOLD_CYCLES=6)
//  1 Reset: pulse sw0 -> reg3=0x0303, reg0=0, mask=0, update_count=0.
//  2 Mode 00, 4 cycles -> reg1=0x0102, mask=0x02, last_reg=1. 4 more -> reg2=0x0203,
//    mask=0x06. 8th tick updates reg1 again (ptr wrap skips 0).
//  3 Mode 11, one step_pulse, then idle -> mask=0x02 for 6 cycles, then 0.
//    A second pulse on the expiry cycle -> mask=0x06, timer restarts.
//  4 Mode 10: wb_we, addr 5, data 0xBEEF -> reg5=0xBEEF next cycle, mask bit5,
//    count+1. addr 0 write -> no change. wb_we in mode 00 -> ignored.
//  5 Wrap: reg1 snooped to 0xFFFF, then mode 00 tick -> reg1=0x0000.
//    70000 snoop writes -> update_count=0xFFFF.
//  6 sw0 asserted mid-step, between clock edges -> outputs at reset values
//    immediately. After release, first tick exactly STEP_PERIOD cycles later.

Source files
------------

// File: rtl/reg_activity_tracker.sv
// Register-file shadow for the debug display: demo activity generator or
// CPU writeback snoop, with a hold-window highlight mask of recent updates.
module reg_activity_tracker #(
  parameter int          NUM_REGS    = 32,
  parameter int          DATA_W      = 32,
  parameter int          STEP_PERIOD = 16_777_216,
  parameter int          HOLD_CYCLES = 8_388_608,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12468
) (
  input  logic                          clock,
  input  logic                          sw0,
  input  logic [1:0]                    mode,
  input  logic                          step_pulse,
  input  logic                          wb_we,
  input  logic [$clog2(NUM_REGS)-1:0]   wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  output logic [NUM_REGS*DATA_W-1:0]    regs_flat,
  output logic [NUM_REGS-1:0]           changed_mask,
  output logic [$clog2(NUM_REGS)-1:0]   last_reg,
  output logic [15:0]                   update_count
);

  localparam int          ADDR_W = $clog2(NUM_REGS);
  localparam int          STEP_W = $clog2(STEP_PERIOD);
  localparam int          HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [31:0] TAPS   = 32'h80200003;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    M_SEQ    = 2'b00,
    M_LFSR   = 2'b01,
    M_SNOOP  = 2'b10,
    M_FREEZE = 2'b11
  } mode_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [1:0]          mode_q, mode_d;

  logic [31:0]       lfsr_n;
  logic [ADDR_W-1:0] lfsr_tgt;
  logic              tick;
  logic              ev;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] val;

  always_comb begin
    regs_d   = regs_q;
    mask_d   = mask_q;
    last_d   = last_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    step_d   = '0;
    hold_d   = '0;
    lfsr_d   = lfsr_q;
    mode_d   = mode;
    tick     = 1'b0;
    ev       = 1'b0;
    idx      = '0;
    val      = '0;
    lfsr_n   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    lfsr_tgt = lfsr_n[ADDR_W-1:0];
    if (lfsr_tgt == '0) lfsr_tgt = ADDR_W'(1);

    // a mode change restarts the timer from zero without ticking
    case (mode_e'(mode))
      M_SEQ, M_LFSR: begin
        if (mode == mode_q) begin
          if (step_q == STEP_LAST) tick = 1'b1;
          else                     step_d = step_q + STEP_W'(1);
        end
      end
      M_FREEZE: tick = step_pulse;
      default:  tick = 1'b0;
    endcase

    if (tick) begin
      ev = 1'b1;
      if (mode == M_LFSR) begin
        lfsr_d = lfsr_n;
        idx    = lfsr_tgt;
        val    = lfsr_n[DATA_W-1:0];
      end else begin
        idx   = ptr_q;
        val   = regs_q[ptr_q] + DATA_W'(1);
        ptr_d = (ptr_q == PTR_LAST) ? ADDR_W'(1) : ptr_q + ADDR_W'(1);
      end
    end else if (mode == M_SNOOP && wb_we && wb_addr != '0) begin
      ev  = 1'b1;
      idx = wb_addr;
      val = wb_data;
    end

    if (ev) begin
      regs_d[idx] = val;
      mask_d[idx] = 1'b1;
      last_d      = idx;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (mask_q != '0) begin
      if (hold_q == HOLD_LAST) mask_d = '0;
      else                     hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge sw0) begin
    if (sw0) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= DATA_W'(32'(i) * 32'h01010101);
      mask_q <= '0;
      last_q <= '0;
      ptr_q  <= ADDR_W'(1);
      cnt_q  <= '0;
      step_q <= '0;
      hold_q <= '0;
      lfsr_q <= LFSR_SEED;
      mode_q <= 2'b00;
    end else begin
      regs_q <= regs_d;
      mask_q <= mask_d;
      last_q <= last_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      hold_q <= hold_d;
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign changed_mask = mask_q;
  assign last_reg     = last_q;
  assign update_count = cnt_q;

endmodule
